// File: rtl/scan_mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : scan_mux_n
//  Description : N-channel registered data multiplexer. In manual mode a
//                channel index is loaded on request; in auto-scan mode the
//                selection steps through every channel, resting DWELL cycles
//                on each, with a wrap pulse on return to channel 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_mux_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      load,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      out_valid,
  output logic                      wrap,
  output logic                      sel_err
);

  // Dwell counter needs at least one bit even when DWELL is 1.
  localparam int                 c_dw_w       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [c_dw_w-1:0]  c_dwell_last = c_dw_w'(DWELL - 1);
  localparam logic [SEL_W-1:0]   c_sel_last   = SEL_W'(CHANNELS - 1);
  // One extra bit so CHANNELS = 2**SEL_W is representable.
  localparam logic [SEL_W:0]     c_channels   = (SEL_W + 1)'(CHANNELS);

  logic [WIDTH-1:0]  w_ch [CHANNELS];
  logic              w_sel_legal;

  logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
  logic [c_dw_w-1:0] dwell_q, dwell_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              wrap_q, wrap_d;
  logic              sel_err_q, sel_err_d;

  // Unpacked view of the flat channel bus.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign w_ch[k] = in[k*WIDTH +: WIDTH];
  end

  assign w_sel_legal = ({1'b0, sel} < c_channels);

  // Selection control: manual load or dwell-timed scan advance.
  always_comb begin
    cur_sel_d = cur_sel_q;
    dwell_d   = dwell_q;
    wrap_d    = 1'b0;
    sel_err_d = 1'b0;
    if (!mode) begin
      // Manual mode keeps the dwell counter parked so a scan always
      // starts with a full dwell on the current channel.
      dwell_d = '0;
      if (load) begin
        if (w_sel_legal) begin
          cur_sel_d = sel;
        end else begin
          sel_err_d = 1'b1;
        end
      end
    end else if (!hold) begin
      if (dwell_q == c_dwell_last) begin
        dwell_d = '0;
        if (cur_sel_q == c_sel_last) begin
          cur_sel_d = '0;
          wrap_d    = 1'b1;
        end else begin
          cur_sel_d = cur_sel_q + SEL_W'(1);
        end
      end else begin
        dwell_d = dwell_q + c_dw_w'(1);
      end
    end
  end

  // Output data follows the pre-edge selection; valid drops on a change.
  always_comb begin
    out_d       = w_ch[cur_sel_q];
    out_valid_d = (cur_sel_d == cur_sel_q);
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel_q   <= '0;
      dwell_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      cur_sel_q   <= cur_sel_d;
      dwell_q     <= dwell_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out       = out_q;
  assign cur_sel   = cur_sel_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;
  assign sel_err   = sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_mux_n
//  Description : Self-checking bench for scan_mux_n; three parameter sets
//                (default, 6 channels, 3 channels with DWELL=1) run side by
//                side against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_mux_n;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: defaults (8 ch, DWELL 4)
  logic [7:0]  a_ch [8];
  logic [63:0] a_in;
  logic        a_mode, a_load, a_hold, a_valid, a_wrap, a_err;
  logic [2:0]  a_sel, a_cur;
  logic [7:0]  a_out;
  // DUT B: 6 channels, DWELL 2
  logic [7:0]  b_ch [6];
  logic [47:0] b_in;
  logic        b_mode, b_load, b_hold, b_valid, b_wrap, b_err;
  logic [2:0]  b_sel, b_cur;
  logic [7:0]  b_out;
  // DUT C: 3 channels, DWELL 1
  logic [7:0]  c_ch [3];
  logic [23:0] c_in;
  logic        c_mode, c_load, c_hold, c_valid, c_wrap, c_err;
  logic [1:0]  c_sel, c_cur;
  logic [7:0]  c_out;

  for (genvar k = 0; k < 8; k++) begin : g_pack_a
    assign a_in[k*8 +: 8] = a_ch[k];
  end
  for (genvar k = 0; k < 6; k++) begin : g_pack_b
    assign b_in[k*8 +: 8] = b_ch[k];
  end
  for (genvar k = 0; k < 3; k++) begin : g_pack_c
    assign c_in[k*8 +: 8] = c_ch[k];
  end

  scan_mux_n u_dut_a (
    .clk(clk), .rst_n(rst_n), .in(a_in), .mode(a_mode), .sel(a_sel),
    .load(a_load), .hold(a_hold), .out(a_out), .cur_sel(a_cur),
    .out_valid(a_valid), .wrap(a_wrap), .sel_err(a_err)
  );

  scan_mux_n #(.WIDTH(8), .CHANNELS(6), .SEL_W(3), .DWELL(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in(b_in), .mode(b_mode), .sel(b_sel),
    .load(b_load), .hold(b_hold), .out(b_out), .cur_sel(b_cur),
    .out_valid(b_valid), .wrap(b_wrap), .sel_err(b_err)
  );

  scan_mux_n #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in(c_in), .mode(c_mode), .sel(c_sel),
    .load(c_load), .hold(c_hold), .out(c_out), .cur_sel(c_cur),
    .out_valid(c_valid), .wrap(c_wrap), .sel_err(c_err)
  );

  // Behavioural model state: observable outputs plus the dwell count.
  typedef struct {
    int cur;
    int dwell;
    int out;
    int valid;
    int wrap;
    int err;
  } mdl_t;

  mdl_t ma, mb, mc;

  // One clock edge of the described behaviour.
  function automatic mdl_t mstep(input mdl_t m, input int nch, input int dw,
                                 input int data, input bit mode, input int sel,
                                 input bit load, input bit hold);
    mdl_t n;
    n      = m;
    n.out  = data;
    n.wrap = 0;
    n.err  = 0;
    if (!mode) begin
      n.dwell = 0;
      if (load) begin
        if (sel < nch) n.cur = sel;
        else           n.err = 1;
      end
    end else if (!hold) begin
      if (m.dwell + 1 >= dw) begin
        n.dwell = 0;
        n.cur   = (m.cur + 1) % nch;
        n.wrap  = (n.cur == 0) ? 1 : 0;
      end else begin
        n.dwell = m.dwell + 1;
      end
    end
    n.valid = (n.cur == m.cur) ? 1 : 0;
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("a_out",   a_out,   ma.out);
    check_eq("a_cur",   a_cur,   ma.cur);
    check_eq("a_valid", a_valid, ma.valid);
    check_eq("a_wrap",  a_wrap,  ma.wrap);
    check_eq("a_err",   a_err,   ma.err);
    check_eq("b_out",   b_out,   mb.out);
    check_eq("b_cur",   b_cur,   mb.cur);
    check_eq("b_valid", b_valid, mb.valid);
    check_eq("b_wrap",  b_wrap,  mb.wrap);
    check_eq("b_err",   b_err,   mb.err);
    check_eq("c_out",   c_out,   mc.out);
    check_eq("c_cur",   c_cur,   mc.cur);
    check_eq("c_valid", c_valid, mc.valid);
    check_eq("c_wrap",  c_wrap,  mc.wrap);
    check_eq("c_err",   c_err,   mc.err);
  endtask

  task automatic zero_models();
    ma = '{default: 0};
    mb = '{default: 0};
    mc = '{default: 0};
  endtask

  // Advance one clock, update the model, compare 1 time unit after the edge.
  task automatic step_all();
    mdl_t na, nb, nc;
    na = mstep(ma, 8, 4, int'(a_ch[ma.cur]), a_mode, int'(a_sel), a_load, a_hold);
    nb = mstep(mb, 6, 2, int'(b_ch[mb.cur]), b_mode, int'(b_sel), b_load, b_hold);
    nc = mstep(mc, 3, 1, int'(c_ch[mc.cur]), c_mode, int'(c_sel), c_load, c_hold);
    @(posedge clk);
    #1;
    if (rst_n) begin
      ma = na;
      mb = nb;
      mc = nc;
    end else begin
      zero_models();
    end
    compare_all();
  endtask

  // Called 1 unit after an edge: pulse reset well between edges.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_a_out",   a_out,   0);
    check_eq("arst_a_cur",   a_cur,   0);
    check_eq("arst_a_valid", a_valid, 0);
    check_eq("arst_a_wrap",  a_wrap,  0);
    check_eq("arst_b_cur",   b_cur,   0);
    check_eq("arst_c_cur",   c_cur,   0);
    zero_models();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {a_mode, a_load, a_hold, a_sel} = '0;
    {b_mode, b_load, b_hold, b_sel} = '0;
    {c_mode, c_load, c_hold, c_sel} = '0;
    for (int k = 0; k < 8; k++) a_ch[k] = 8'(8'h10 + k);
    for (int k = 0; k < 6; k++) b_ch[k] = 8'(8'h20 + k);
    for (int k = 0; k < 3; k++) c_ch[k] = 8'(8'h30 + k);
    zero_models();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out",   a_out,   0);
    check_eq("rst_cur",   a_cur,   0);
    check_eq("rst_valid", a_valid, 0);
    check_eq("rst_wrap",  a_wrap,  0);
    check_eq("rst_err",   a_err,   0);
    rst_n = 1'b1;

    // First edge after reset loads channel 0
    step_all();
    check_eq("post_rst_out",   a_out,   8'h10);
    check_eq("post_rst_valid", a_valid, 1);

    // Manual select of channel 5
    a_load = 1'b1; a_sel = 3'd5;
    b_load = 1'b1; b_sel = 3'd2;
    step_all();
    check_eq("man_cur",   a_cur,   5);
    check_eq("man_valid0", a_valid, 0);
    a_load = 1'b0; b_load = 1'b0;
    step_all();
    check_eq("man_out",    a_out,   8'h15);
    check_eq("man_valid1", a_valid, 1);

    // Reloading the current channel is not a change
    a_load = 1'b1; a_sel = 3'd5;
    step_all();
    check_eq("reload_valid", a_valid, 1);

    // Illegal select on the 6-channel instance
    a_load = 1'b0;
    b_load = 1'b1; b_sel = 3'd7;
    step_all();
    check_eq("ill_err", b_err, 1);
    check_eq("ill_cur", b_cur, 2);
    check_eq("ill_out", b_out, 8'h22);
    b_load = 1'b0;
    step_all();
    check_eq("ill_err_clr", b_err, 0);

    // Return A to channel 0, then scan A and C
    a_load = 1'b1; a_sel = 3'd0;
    step_all();
    a_load = 1'b0;
    step_all();
    a_mode = 1'b1; c_mode = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step_all();
      check_eq("scan_cur",  a_cur,  (i / 4) % 8);
      check_eq("scan_wrap", a_wrap, (i == 32) ? 1 : 0);
      if (i <= 6) begin
        check_eq("d1_cur",   c_cur,   i % 3);
        check_eq("d1_wrap",  c_wrap,  (i % 3 == 0) ? 1 : 0);
        check_eq("d1_valid", c_valid, 0);
      end
    end

    // Hold at channel 3, dwell count 2
    repeat (14) step_all();
    check_eq("pre_hold_cur", a_cur, 3);
    a_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_all();
      check_eq("hold_cur",  a_cur,  3);
      check_eq("hold_wrap", a_wrap, 0);
    end
    a_hold = 1'b0;
    step_all();
    check_eq("rel1_cur", a_cur, 3);
    step_all();
    check_eq("rel2_cur", a_cur, 4);

    // Asynchronous reset mid-scan at channel 6
    repeat (8) step_all();
    check_eq("pre_arst_cur", a_cur, 6);
    async_reset();
    step_all();
    check_eq("arst_first_out",   a_out,   8'h10);
    check_eq("arst_first_valid", a_valid, 1);

    // Leaving scan mode keeps the selection
    repeat (3) step_all();
    check_eq("scan_back_cur", a_cur, 1);
    a_mode = 1'b0;
    step_all();
    check_eq("mode0_cur", a_cur, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      a_mode = ($urandom_range(0, 2) != 0);
      b_mode = ($urandom_range(0, 2) != 0);
      c_mode = ($urandom_range(0, 2) != 0);
      a_hold = ($urandom_range(0, 4) == 0);
      b_hold = ($urandom_range(0, 4) == 0);
      c_hold = ($urandom_range(0, 4) == 0);
      a_load = $urandom_range(0, 1) == 1;
      b_load = $urandom_range(0, 1) == 1;
      c_load = $urandom_range(0, 1) == 1;
      a_sel  = 3'($urandom_range(0, 7));
      b_sel  = 3'($urandom_range(0, 7));
      c_sel  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 8; k++) a_ch[k] = 8'($urandom);
        for (int k = 0; k < 6; k++) b_ch[k] = 8'($urandom);
        for (int k = 0; k < 3; k++) c_ch[k] = 8'($urandom);
      end
      if ($urandom_range(0, 149) == 0) async_reset();
      step_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scan_mux_n.md
SCAN_MUX_N -- requirements
Module: scan_mux_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each input channel and of out.
REQ-002 SHALL have parameter CHANNELS, default 8: number of input channels, legal range 2..256.
REQ-003 SHALL have parameter SEL_W, default 3: select width, equal to ceil(log2(CHANNELS)).
REQ-004 SHALL have parameter DWELL, default 4: clock cycles spent on each channel in scan mode, legal range >= 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port in, input, CHANNELS*WIDTH bits: channel k occupies in[k*WIDTH +: WIDTH].
REQ-008 SHALL have port mode, input, 1 bit: 0 = manual select, 1 = auto-scan.
REQ-009 SHALL have port sel, input, SEL_W bits: requested channel in manual mode.
REQ-010 SHALL have port load, input, 1 bit: in manual mode, capture sel on this edge.
REQ-011 SHALL have port hold, input, 1 bit: in scan mode, freeze the dwell counter and cur_sel.
REQ-012 SHALL have port out, output, WIDTH bits: registered selected channel data.
REQ-013 SHALL have port cur_sel, output, SEL_W bits: currently selected channel index.
REQ-014 SHALL have port out_valid, output, 1 bit: high when out holds data of channel cur_sel.
REQ-015 SHALL have port wrap, output, 1 bit: one-cycle pulse when scan advances from CHANNELS-1 to 0.
REQ-016 SHALL have port sel_err, output, 1 bit: one-cycle pulse when load is high with sel >= CHANNELS.

Function
REQ-017 out SHALL register in[cur_sel] on every edge, so out lags a cur_sel change by exactly one cycle.
REQ-018 out_valid SHALL be 0 in the cycle after any edge that changes cur_sel, and 1 after any edge that leaves cur_sel unchanged.
REQ-019 Manual mode, with load=1 and sel < CHANNELS: cur_sel SHALL become sel on the edge; loading the current value SHALL not count as a change.
REQ-020 Manual mode, with load=1 and sel >= CHANNELS: cur_sel SHALL be unchanged and sel_err SHALL pulse for one cycle.
REQ-021 Manual mode: load SHALL be ignored when mode=1; the dwell counter SHALL be held at 0.
REQ-022 Scan mode: the internal dwell counter SHALL count 0..DWELL-1; when it is at DWELL-1 with hold=0, it SHALL return to 0 and cur_sel SHALL advance by 1.
REQ-023 Scan mode wrap-around: advancing from CHANNELS-1 SHALL give cur_sel = 0, with wrap=1 for that cycle; wrap SHALL be 0 at all other times.
REQ-024 Scan mode with hold=1: the dwell counter, cur_sel and wrap SHALL be frozen at the cycle's values, except that wrap SHALL be 0; out SHALL keep tracking in[cur_sel].
REQ-025 On the first edge with mode=1 after mode=0, the dwell counter SHALL be at 0 and the scan SHALL start from the current cur_sel.
REQ-026 When DWELL=1, cur_sel SHALL advance on every unheld edge; out_valid SHALL then stay 0 while scanning.
REQ-027 A mode change from 1 to 0 SHALL keep cur_sel unchanged.
REQ-028 Non-power-of-two CHANNELS SHALL never produce cur_sel >= CHANNELS.

Reset
REQ-029 rst_n=0 SHALL immediately force all registered state to reset values, independent of clk: out=0, cur_sel=0, out_valid=0, wrap=0, sel_err=0, dwell counter=0.
REQ-030 Reset asserted mid-scan SHALL abort the dwell with no wrap or sel_err pulse.
REQ-031 After rst_n rises, the first edge SHALL load out with in[0] and set out_valid=1.

Verification
REQ-032 Manual select: use defaults with channel k = 8'h10+k, mode=0, load=1, sel=5 for one cycle -> next cycle cur_sel=5 and out_valid=0; one cycle later out=8'h15 and out_valid=1.
REQ-033 Illegal select: CHANNELS=6, SEL_W=3, load=1, sel=7 -> sel_err=1 for one cycle; cur_sel and out unchanged.
REQ-034 Scan and wrap: use defaults with mode=1 from cur_sel=0 -> cur_sel steps every 4 cycles through 0..7; wrap=1 exactly in the cycle cur_sel returns to 0, i.e. 32 cycles after scan start.
REQ-035 Hold: with mode=1, hold=1 for 10 cycles at dwell count 2, cur_sel=3 -> cur_sel stays 3 and wrap stays 0; after release, cur_sel=4 after 2 more edges.
REQ-036 Asynchronous reset mid-scan: drop rst_n between edges with cur_sel=6 -> outputs are 0 before the next clk edge; after release, out=in[0] on the first edge.
REQ-037 DWELL=1, CHANNELS=3 -> cur_sel runs 0,1,2,0 on consecutive edges, with wrap on every third edge and out_valid held at 0.
